// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle fetch/decode/execute controller.
// Holds the state enum, instruction codes, select one-hots and the output bundle.
package multicycle_ctrl_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IDLE, S_IF1, S_IF2, S_UPDPC, S_DEC,
    S_MOVI, S_GETA, S_GETB, S_ALU, S_WRR,
    S_LDA, S_LDC, S_LDAD, S_LDM, S_LDW,
    S_STA, S_STC, S_STAD, S_STB, S_STB2, S_STM,
    S_DONE, S_HALT, S_ERR
  } state_t;

  // {opcode, op} as seen by the decoder
  localparam logic [4:0] OP_MOVI = 5'b11010;
  localparam logic [4:0] OP_MOVR = 5'b11000;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [4:0] OP_CMP  = 5'b10101;
  localparam logic [4:0] OP_LDR  = 5'b01100;
  localparam logic [4:0] OP_STR  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11100;

  localparam logic [2:0] NSEL_RN = 3'b100;
  localparam logic [2:0] NSEL_RD = 3'b010;
  localparam logic [2:0] NSEL_RM = 3'b001;

  localparam logic [3:0] VSEL_MDATA  = 4'b1000;
  localparam logic [3:0] VSEL_SXIMM8 = 4'b0100;
  localparam logic [3:0] VSEL_PC     = 4'b0010;
  localparam logic [3:0] VSEL_C      = 4'b0001;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  typedef struct packed {
    logic [1:0] mem_cmd;
    logic [2:0] nsel;
    logic [3:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic       w;
    logic       halted;
    logic       err;
    logic       fetch;
  } ctrl_t;

  // Output pattern for a state; ALU needs the instruction to pick MOV-reg/CMP behaviour.
  function automatic ctrl_t state_outputs(input state_t st, input logic [4:0] instr_op);
    ctrl_t c;
    c = '0;
    case (st)
      S_IDLE:  c.w = 1'b1;
      S_IF1, S_IF2: begin
        c.mem_cmd = MEM_READ;
        c.fetch   = 1'b1;
      end
      S_MOVI: begin
        c.nsel  = NSEL_RN;
        c.vsel  = VSEL_SXIMM8;
        c.write = 1'b1;
      end
      S_GETA, S_LDA, S_STA: begin
        c.nsel  = NSEL_RN;
        c.loada = 1'b1;
      end
      S_GETB: begin
        c.nsel  = NSEL_RM;
        c.loadb = 1'b1;
      end
      S_ALU: begin
        c.asel  = (instr_op == OP_MOVR);
        c.loads = (instr_op == OP_CMP);
        c.loadc = (instr_op != OP_CMP);
      end
      S_WRR: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_C;
        c.write = 1'b1;
      end
      S_LDC, S_STC: begin
        c.bsel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_LDM:   c.mem_cmd = MEM_READ;
      S_LDW: begin
        c.nsel  = NSEL_RD;
        c.vsel  = VSEL_MDATA;
        c.write = 1'b1;
      end
      S_STB: begin
        c.nsel  = NSEL_RD;
        c.loadb = 1'b1;
      end
      S_STB2: begin
        c.asel  = 1'b1;
        c.loadc = 1'b1;
      end
      S_STM:   c.mem_cmd = MEM_WRITE;
      S_HALT:  c.halted = 1'b1;
      S_ERR:   c.err = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive not-ready cycles of one memory access; expired flags the
// miss that brings the count up to MEM_TIMEOUT.
module mem_wait_timer
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = count && (cnt == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Fetch/decode/execute sequencer for the simple RISC datapath: owns the PC, the
// memory command bus and every datapath strobe.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int PC_W        = 9,
  parameter int AUTO_RUN    = 1,
  parameter int MEM_TIMEOUT = 15,
  parameter int RESET_PC    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s,
  input  logic [2:0]      opcode,
  input  logic [1:0]      op,
  input  logic            mem_ready,
  input  logic [PC_W-1:0] alu_addr,
  output logic [1:0]      mem_cmd,
  output logic [PC_W-1:0] mem_addr,
  output logic            load_ir,
  output logic [2:0]      nsel,
  output logic [3:0]      vsel,
  output logic            loada,
  output logic            loadb,
  output logic            loadc,
  output logic            loads,
  output logic            asel,
  output logic            bsel,
  output logic            write,
  output logic [PC_W-1:0] pc,
  output logic            w,
  output logic            halted,
  output logic            err
);

  // state        | meaning
  // RST/IDLE     | after reset / waiting for s (step mode)
  // IF1/IF2      | fetch request / wait for instruction word
  // UPDPC/DEC    | advance pc / decode {opcode,op}
  // MOVI..WRR    | immediate move and register ALU ops
  // LD*/ST*      | address calc, memory wait, writeback
  // DONE/HALT/ERR| end of instruction / sticky stop / sticky trap

  state_t          state;
  state_t          nxt;
  ctrl_t           ctrl;
  logic [PC_W-1:0] addr;
  logic [4:0]      instr_op;
  logic            in_wait;
  logic            tmr_expired;
  logic            next_after_done;

  assign instr_op        = {opcode, op};
  assign in_wait         = (state == S_IF2) || (state == S_LDM) || (state == S_STM);
  assign next_after_done = (AUTO_RUN != 0);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (!in_wait),
    .count  (in_wait && !mem_ready),
    .expired(tmr_expired)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_RST:   nxt = next_after_done ? S_IF1 : S_IDLE;
      S_IDLE:  nxt = s ? S_IF1 : S_IDLE;
      S_IF1:   nxt = S_IF2;
      S_IF2: begin
        if (mem_ready)        nxt = S_UPDPC;
        else if (tmr_expired) nxt = S_ERR;
      end
      S_UPDPC: nxt = S_DEC;
      S_DEC: begin
        if (instr_op == OP_MOVI)           nxt = S_MOVI;
        else if (instr_op == OP_MOVR)      nxt = S_GETB;
        else if (instr_op[4:2] == OPC_ALU) nxt = S_GETA;
        else if (instr_op == OP_LDR)       nxt = S_LDA;
        else if (instr_op == OP_STR)       nxt = S_STA;
        else if (instr_op == OP_HALT)      nxt = S_HALT;
        else                               nxt = S_ERR;
      end
      S_MOVI:  nxt = S_DONE;
      S_GETA:  nxt = S_GETB;
      S_GETB:  nxt = S_ALU;
      S_ALU:   nxt = (instr_op == OP_CMP) ? S_DONE : S_WRR;
      S_WRR:   nxt = S_DONE;
      S_LDA:   nxt = S_LDC;
      S_LDC:   nxt = S_LDAD;
      S_LDAD:  nxt = S_LDM;
      S_LDM: begin
        if (mem_ready)        nxt = S_LDW;
        else if (tmr_expired) nxt = S_ERR;
      end
      S_LDW:   nxt = S_DONE;
      S_STA:   nxt = S_STC;
      S_STC:   nxt = S_STAD;
      S_STAD:  nxt = S_STB;
      S_STB:   nxt = S_STB2;
      S_STB2:  nxt = S_STM;
      S_STM: begin
        if (mem_ready)        nxt = S_DONE;
        else if (tmr_expired) nxt = S_ERR;
      end
      S_DONE:  nxt = next_after_done ? S_IF1 : S_IDLE;
      S_HALT:  nxt = S_HALT;
      S_ERR:   nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      ctrl  <= '0;
      pc    <= PC_W'(RESET_PC);
      addr  <= '0;
    end else begin
      state <= nxt;
      ctrl  <= state_outputs(nxt, instr_op);
      if (state == S_UPDPC) begin
        pc <= pc + PC_W'(1);
      end
      if ((state == S_LDAD) || (state == S_STAD)) begin
        addr <= alu_addr;
      end
    end
  end

  // The IR must capture the word in the very cycle memory presents it.
  assign load_ir  = (state == S_IF2) && mem_ready && !reset;
  assign mem_addr = ctrl.fetch ? pc : addr;
  assign mem_cmd  = ctrl.mem_cmd;
  assign nsel     = ctrl.nsel;
  assign vsel     = ctrl.vsel;
  assign loada    = ctrl.loada;
  assign loadb    = ctrl.loadb;
  assign loadc    = ctrl.loadc;
  assign loads    = ctrl.loads;
  assign asel     = ctrl.asel;
  assign bsel     = ctrl.bsel;
  assign write    = ctrl.write;
  assign w        = ctrl.w;
  assign halted   = ctrl.halted;
  assign err      = ctrl.err;

endmodule
